ddr_burst_arbiter: RTL and testbench
====================================

Name: ddr_burst_arbiter

Overview:
- Parametrised successor to the single-client DDR/cache bridge. Arbitrates NUM_CH independent burst clients (ISA cache, data cache, jump-address table, loader, …) onto one DDR controller burst port.
- Uses round-robin grant and width adaptation between CH_DATA_WIDTH and DDR_DATA_WIDTH.
- Adds per-burst length checking, beat accounting and a finish watchdog, none of which the previous block had.

Parameters:
- NUM_CH, 4: number of client channels (2..8).
- DDR_DATA_WIDTH, 128: controller data width.
- DDR_ADDR_WIDTH, 28: controller address width.
- CH_DATA_WIDTH, 32: client data width (≤ DDR_DATA_WIDTH).
- LEN_WIDTH, 10: burst length field width.
- MAX_BURST_LEN, 64: largest legal burst, in beats.
- TIMEOUT, 1024: cycles allowed from request issue to finish.

Ports:
- mem_clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel request, level.
- ch_we  in  NUM_CH  1 = write burst, 0 = read burst.
- ch_addr  in  NUM_CH*DDR_ADDR_WIDTH  start addresses, flattened, channel 0 in LSBs.
- ch_len  in  NUM_CH*LEN_WIDTH  burst lengths in beats, flattened.
- ch_wdata  in  NUM_CH*CH_DATA_WIDTH  write data, flattened.
- ch_grant  out  NUM_CH  one-hot; high for the whole transaction.
- ch_wdata_req  out  NUM_CH  write beat consumed this cycle; client advances to its next word.
- ch_rdata  out  CH_DATA_WIDTH  shared read data.
- ch_rvalid  out  NUM_CH  read beat valid for that channel.
- ch_done  out  NUM_CH  1-cycle pulse at successful end of a transaction.
- ch_err  out  NUM_CH  1-cycle pulse on length error, beat mismatch or timeout.
- rd_burst_req, wr_burst_req  out  1  controller requests.
- rd_burst_len, wr_burst_len  out  LEN_WIDTH  burst lengths.
- rd_burst_addr, wr_burst_addr  out  DDR_ADDR_WIDTH  burst start addresses.
- rd_burst_data_valid  in  1  controller read beat valid.
- wr_burst_data_req  in  1  controller ready for a write beat.
- rd_burst_data  in  DDR_DATA_WIDTH  read beat data.
- wr_burst_data  out  DDR_DATA_WIDTH  write beat data.
- rd_burst_finish, wr_burst_finish  in  1  burst complete.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 and state goes to IDLE.
  - Round-robin pointer goes to channel 0.
  - Any in-flight burst is abandoned without a done or err pulse.
- States: IDLE, CHECK, RD, WR, FIN, ERR.
- IDLE:
  - If any ch_req is high, grant the first requesting channel at or after the pointer, searching upward with wrap.
  - Latch that channel's we, addr and len, assert its ch_grant, and go to CHECK on the next edge.
- CHECK:
  - If the latched len is 0 or greater than MAX_BURST_LEN, go to ERR. No controller request is issued.
  - Otherwise set the rd_* or wr_* addr/len from the latched values, assert the matching *_burst_req, clear the beat counter and the watchdog, and go to RD or WR.
- Requests are held high until the matching finish is seen.
- Client inputs are ignored after latching. Dropping ch_req mid-transaction does not abort the burst.
- RD:
  - On each rd_burst_data_valid, register ch_rdata = rd_burst_data[CH_DATA_WIDTH-1:0] and pulse the granted ch_rvalid one cycle later (latency 1). Increment the beat counter.
  - On rd_burst_finish, drop rd_burst_req and go to FIN.
  - If valid and finish arrive in the same cycle, count the beat first.
- WR:
  - ch_wdata_req is combinational: wr_burst_data_req AND the granted bit.
  - On the same edge, register wr_burst_data = zero-extended ch_wdata of the granted channel, and increment the beat counter.
  - On wr_burst_finish, drop wr_burst_req and go to FIN.
- FIN:
  - If the beat counter equals the latched len, pulse ch_done; otherwise pulse ch_err.
  - Clear the grant, set pointer = granted index + 1 (mod NUM_CH), and return to IDLE.
  - A channel therefore cannot win twice in a row while others are requesting.
- Watchdog:
  - Counts cycles in RD/WR.
  - On reaching TIMEOUT-1, drop both requests and go to ERR.
- ERR: pulse ch_err for the granted channel, clear the grant, advance the pointer, and return to IDLE.
- Data paths: wr_burst_data is 0 outside WR. ch_rdata holds its last value.
- Minimum gap between transactions: IDLE→CHECK→issue takes 2 cycles; FIN→IDLE takes 1 cycle.

Test Plan:
- Single read: ch1 requests read, addr 0x0008000, len 4; controller returns 4 beats 0xA..0xD then finish → ch_grant=0010; rd_burst_addr=0x0008000, len=4; ch_rvalid[1] pulses 4 times with ch_rdata 0xA..0xD one cycle after each valid; ch_done[1] pulses.
- Round-robin: ch0 and ch2 hold requests continuously from reset → grant order ch0, ch2, ch0, ch2; ch1 and ch3 are never granted.
- Write packing: ch3 writes len 3 with CH_DATA_WIDTH=32, data 0x11/0x22/0x33 advanced on ch_wdata_req → wr_burst_data = 128-bit zero-extended 0x11, 0x22, 0x33; ch_done[3] pulses.
- Length errors: len 0 and len 65 → no rd_burst_req or wr_burst_req is ever raised; ch_err pulses 2 cycles after the request; pointer advances.
- Timeout/mismatch: read len 8 with no finish → rd_burst_req drops after 1024 cycles and ch_err pulses. Read len 8 where finish arrives after 6 beats → ch_err, not ch_done.
- Reset mid-burst: rst_n low during WR → all requests, grants and data go to 0 immediately; no done or err pulse; after release, ch0 has priority.

Source files
------------

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
// Round-robin arbiter that multiplexes NUM_CH burst clients onto a single
// DDR controller burst port. It adapts CH_DATA_WIDTH client words to
// DDR_DATA_WIDTH controller beats, checks burst lengths, counts beats and
// guards every controller burst with a finish watchdog.
//
// Ports
//   mem_clk, rst_n            clock, asynchronous active-low reset
//   ch_req/we/addr/len/wdata  per-channel client request (flattened, ch0 in LSBs)
//   ch_grant                  one-hot grant, high for the whole transaction
//   ch_wdata_req              write word consumed this cycle (combinational)
//   ch_rdata, ch_rvalid       shared read data, per-channel read strobe
//   ch_done, ch_err           one-cycle completion / failure pulses
//   rd_burst_*, wr_burst_*    DDR controller burst interface
module ddr_burst_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int CH_DATA_WIDTH  = 32,
    parameter int LEN_WIDTH      = 10,
    parameter int MAX_BURST_LEN  = 64,
    parameter int TIMEOUT        = 1024
) (
    input  logic                                mem_clk,
    input  logic                                rst_n,
    input  logic [NUM_CH-1:0]                   ch_req,
    input  logic [NUM_CH-1:0]                   ch_we,
    input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]    ch_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]         ch_len,
    input  logic [NUM_CH*CH_DATA_WIDTH-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]                   ch_grant,
    output logic [NUM_CH-1:0]                   ch_wdata_req,
    output logic [CH_DATA_WIDTH-1:0]            ch_rdata,
    output logic [NUM_CH-1:0]                   ch_rvalid,
    output logic [NUM_CH-1:0]                   ch_done,
    output logic [NUM_CH-1:0]                   ch_err,
    output logic                                rd_burst_req,
    output logic                                wr_burst_req,
    output logic [LEN_WIDTH-1:0]                rd_burst_len,
    output logic [LEN_WIDTH-1:0]                wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0]           rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]           wr_burst_addr,
    input  logic                                rd_burst_data_valid,
    input  logic                                wr_burst_data_req,
    input  logic [DDR_DATA_WIDTH-1:0]           rd_burst_data,
    output logic [DDR_DATA_WIDTH-1:0]           wr_burst_data,
    input  logic                                rd_burst_finish,
    input  logic                                wr_burst_finish
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = LEN_WIDTH + 1;  // headroom so over-long bursts still mismatch
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]        WD_LAST = TW'(TIMEOUT - 1);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST_LEN);
    localparam logic [IW-1:0]        LAST_CH = IW'(NUM_CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD, S_WR, S_FIN, S_ERR} state_e;

    state_e                     state_q;
    logic [IW-1:0]              ptr_q, gnt_idx_q;
    logic                       we_q;
    logic [DDR_ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [BW-1:0]              beat_q;
    logic [TW-1:0]              wdog_q;
    logic [NUM_CH-1:0]          grant_q, rvalid_q, done_q, err_q;
    logic [CH_DATA_WIDTH-1:0]   rdata_q;
    logic                       rd_req_q, wr_req_q;
    logic [LEN_WIDTH-1:0]       rd_len_q, wr_len_q;
    logic [DDR_ADDR_WIDTH-1:0]  rd_addr_q, wr_addr_q;
    logic [DDR_DATA_WIDTH-1:0]  wdata_q;

    // Round-robin pick: scan downward so the lowest offset from the
    // pointer is the last (winning) assignment.
    logic                       pick_vld_d;
    logic [IW-1:0]              pick_idx_d;
    logic [NUM_CH-1:0]          pick_oh_d;
    int                         c;

    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        c          = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = (int'(ptr_q) + i) % NUM_CH;
            if (ch_req[c]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = IW'(c);
            end
        end
        pick_oh_d             = '0;
        pick_oh_d[pick_idx_d] = 1'b1;
    end

    logic [IW-1:0] ptr_next;
    assign ptr_next = (gnt_idx_q == LAST_CH) ? '0 : gnt_idx_q + 1'b1;

    logic len_bad;
    assign len_bad = (len_q == '0) || (len_q > MAX_LEN);

    logic [CH_DATA_WIDTH-1:0] gnt_wdata;
    assign gnt_wdata = ch_wdata[gnt_idx_q*CH_DATA_WIDTH +: CH_DATA_WIDTH];

    logic [BW-1:0] beat_inc;
    assign beat_inc = (beat_q == '1) ? beat_q : beat_q + 1'b1;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wdog_q    <= '0;
            grant_q   <= '0;
            rvalid_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_len_q  <= '0;
            wr_len_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            // pulses default low every cycle
            rvalid_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    wdata_q <= '0;
                    if (pick_vld_d) begin
                        gnt_idx_q <= pick_idx_d;
                        grant_q   <= pick_oh_d;
                        we_q      <= ch_we[pick_idx_d];
                        addr_q    <= ch_addr[pick_idx_d*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
                        len_q     <= ch_len[pick_idx_d*LEN_WIDTH +: LEN_WIDTH];
                        state_q   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    beat_q <= '0;
                    wdog_q <= '0;
                    if (len_bad) begin
                        state_q <= S_ERR;
                    end else if (we_q) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_len_q  <= len_q;
                        state_q   <= S_WR;
                    end else begin
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= addr_q;
                        rd_len_q  <= len_q;
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    if (rd_burst_data_valid) begin
                        rdata_q  <= rd_burst_data[CH_DATA_WIDTH-1:0];
                        rvalid_q <= grant_q;
                        beat_q   <= beat_inc;
                    end
                    // finish wins over a watchdog expiring in the same cycle
                    if (rd_burst_finish) begin
                        rd_req_q <= 1'b0;
                        state_q  <= S_FIN;
                    end else if (wdog_q == WD_LAST) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        state_q  <= S_ERR;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_WR: begin
                    if (wr_burst_data_req) begin
                        wdata_q <= DDR_DATA_WIDTH'(gnt_wdata);
                        beat_q  <= beat_inc;
                    end
                    if (wr_burst_finish) begin
                        wr_req_q <= 1'b0;
                        wdata_q  <= '0;
                        state_q  <= S_FIN;
                    end else if (wdog_q == WD_LAST) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        wdata_q  <= '0;
                        state_q  <= S_ERR;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_FIN: begin
                    if (beat_q == {1'b0, len_q}) done_q <= grant_q;
                    else                         err_q  <= grant_q;
                    grant_q <= '0;
                    ptr_q   <= ptr_next;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    err_q   <= grant_q;
                    grant_q <= '0;
                    ptr_q   <= ptr_next;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Consumption strobe must be same-cycle so the client can advance its word.
    assign ch_wdata_req  = (state_q == S_WR) ? (grant_q & {NUM_CH{wr_burst_data_req}}) : '0;
    assign ch_grant      = grant_q;
    assign ch_rdata      = rdata_q;
    assign ch_rvalid     = rvalid_q;
    assign ch_done       = done_q;
    assign ch_err        = err_q;
    assign rd_burst_req  = rd_req_q;
    assign wr_burst_req  = wr_req_q;
    assign rd_burst_len  = rd_len_q;
    assign wr_burst_len  = wr_len_q;
    assign rd_burst_addr = rd_addr_q;
    assign wr_burst_addr = wr_addr_q;
    assign wr_burst_data = wdata_q;

    // Upper read-beat bits are not forwarded to the narrower clients.
    generate
        if (DDR_DATA_WIDTH > CH_DATA_WIDTH) begin : g_rd_upper
            logic unused_rd_upper;
            assign unused_rd_upper = ^rd_burst_data[DDR_DATA_WIDTH-1:CH_DATA_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter. The bench plays both the
// clients and the DDR controller, predicts every output cycle by cycle from
// transaction-level rules and compares on the falling edge.
module tb_ddr_burst_arbiter;
    localparam int N    = 4;
    localparam int DW   = 128;
    localparam int AW   = 28;
    localparam int CW   = 32;
    localparam int LW   = 10;
    localparam int MAXL = 64;
    localparam int TMO  = 1024;

    logic              mem_clk = 1'b0;
    logic              rst_n   = 1'b1;
    logic [N-1:0]      ch_req = '0, ch_we = '0;
    logic [N*AW-1:0]   ch_addr = '0;
    logic [N*LW-1:0]   ch_len = '0;
    logic [N*CW-1:0]   ch_wdata = '0;
    logic [N-1:0]      ch_grant, ch_wdata_req, ch_rvalid, ch_done, ch_err;
    logic [CW-1:0]     ch_rdata;
    logic              rd_burst_req, wr_burst_req;
    logic [LW-1:0]     rd_burst_len, wr_burst_len;
    logic [AW-1:0]     rd_burst_addr, wr_burst_addr;
    logic              rd_burst_data_valid = 1'b0, wr_burst_data_req = 1'b0;
    logic [DW-1:0]     rd_burst_data = '0;
    logic [DW-1:0]     wr_burst_data;
    logic              rd_burst_finish = 1'b0, wr_burst_finish = 1'b0;

    always #5 mem_clk = ~mem_clk;

    ddr_burst_arbiter #(
        .NUM_CH(N), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .CH_DATA_WIDTH(CW),
        .LEN_WIDTH(LW), .MAX_BURST_LEN(MAXL), .TIMEOUT(TMO)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_len(ch_len), .ch_wdata(ch_wdata),
        .ch_grant(ch_grant), .ch_wdata_req(ch_wdata_req), .ch_rdata(ch_rdata),
        .ch_rvalid(ch_rvalid), .ch_done(ch_done), .ch_err(ch_err),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_data(rd_burst_data), .wr_burst_data(wr_burst_data),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
    );

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    // expected outputs for the current cycle
    logic [N-1:0]  exp_gnt = '0, exp_rv = '0, exp_wdreq = '0, exp_done = '0, exp_err = '0;
    logic          exp_rreq = 1'b0, exp_wreq = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [LW-1:0] exp_len = '0;
    logic [CW-1:0] exp_rd = '0;
    logic [DW-1:0] exp_wd = '0;
    int            ptr_m = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge mem_clk) begin
        if (chk_en) begin
            check("grant", ch_grant, exp_gnt);
            check("rd_req", rd_burst_req, exp_rreq);
            check("wr_req", wr_burst_req, exp_wreq);
            if (exp_rreq) begin
                check("rd_addr", rd_burst_addr, exp_addr);
                check("rd_len", rd_burst_len, exp_len);
            end
            if (exp_wreq) begin
                check("wr_addr", wr_burst_addr, exp_addr);
                check("wr_len", wr_burst_len, exp_len);
            end
            check("rvalid", ch_rvalid, exp_rv);
            if (exp_rv != '0) check("rdata", ch_rdata, exp_rd);
            check("wdata_req", ch_wdata_req, exp_wdreq);
            check("wr_data", wr_burst_data, exp_wd);
            check("done", ch_done, exp_done);
            check("err", ch_err, exp_err);
        end
    end

    task automatic tick;
        @(posedge mem_clk);
        #1;
    endtask

    // first requester at or after the model pointer, wrapping upward
    function automatic int rr_pick(input logic [N-1:0] reqv);
        for (int i = 0; i < N; i++)
            if (reqv[(ptr_m + i) % N]) return (ptr_m + i) % N;
        return -1;
    endfunction

    task automatic clear_exp;
        exp_gnt = '0; exp_rv = '0; exp_wdreq = '0; exp_done = '0; exp_err = '0;
        exp_rreq = 1'b0; exp_wreq = 1'b0; exp_wd = '0;
    endtask

    task automatic scramble(input int keep_wdata_ch);
        for (int k = 0; k < N; k++) begin
            ch_we[k] = 1'($urandom);
            ch_addr[k*AW +: AW] = AW'($urandom);
            ch_len[k*LW +: LW] = LW'($urandom);
            if (k != keep_wdata_ch) ch_wdata[k*CW +: CW] = $urandom;
        end
    endtask

    // One whole transaction: nb beats supplied by the controller, dir selects
    // deterministic data (read beat k = dbase+k, write word k = dbase*(k+1)).
    task automatic txn(input logic [N-1:0] reqv, input logic we, input logic [AW-1:0] addr,
                       input logic [LW-1:0] len, input int nb, input bit same_fin, input bit tmo,
                       input int rst_at, input logic [31:0] dbase, input bit dir);
        int win, sent, widx;
        bit v, f, fin;
        logic [DW-1:0] d;
        logic [N-1:0] oh;
        logic [CW-1:0] words[$];
        win = rr_pick(reqv);
        oh = '0;
        oh[win] = 1'b1;
        scramble(-1);
        ch_we[win] = we;
        ch_addr[win*AW +: AW] = addr;
        ch_len[win*LW +: LW] = len;
        for (int k = 0; k < nb + 2; k++) words.push_back(dir ? dbase * (k + 1) : $urandom);
        ch_wdata[win*CW +: CW] = words[0];
        ch_req = reqv;
        tick;
        exp_gnt = oh;
        ch_req = '0;
        scramble(win);       // latched values must not follow the client
        if (len == '0 || int'(len) > MAXL) begin
            tick;
            tick;
            exp_gnt = '0; exp_err = oh;
            tick;
            exp_err = '0;
            ptr_m = (win + 1) % N;
            return;
        end
        exp_addr = addr; exp_len = len;
        tick;
        if (we) exp_wreq = 1'b1; else exp_rreq = 1'b1;
        if (tmo) begin
            repeat (TMO) tick;
            exp_rreq = 1'b0; exp_wreq = 1'b0;
            tick;
            exp_gnt = '0; exp_err = oh;
            tick;
            exp_err = '0;
            ptr_m = (win + 1) % N;
            return;
        end
        sent = 0; fin = 0; widx = 0;
        while (!fin) begin
            if (rst_at > 0 && sent == rst_at) begin
                rst_n = 1'b0;
                ch_req = '0; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
                rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
                clear_exp();
                tick;
                tick;
                rst_n = 1'b1;
                ptr_m = 0;
                return;
            end
            v = (sent < nb) && (dir || $urandom_range(0, 2) != 0);
            f = (sent == nb) || (v && sent == nb - 1 && same_fin && !we);
            d = dir ? DW'(dbase + sent) : {$urandom, $urandom, $urandom, $urandom};
            if (we) begin
                wr_burst_data_req = v; wr_burst_finish = f;
                exp_wdreq = v ? oh : '0;
            end else begin
                rd_burst_data_valid = v; rd_burst_data = d; rd_burst_finish = f;
            end
            tick;
            exp_wdreq = '0;
            if (we) begin
                if (v) begin
                    exp_wd = DW'(words[widx]);
                    widx++;
                    ch_wdata[win*CW +: CW] = words[widx];
                end
                if (f) exp_wd = '0;
            end else begin
                exp_rv = v ? oh : '0;
                if (v) exp_rd = d[CW-1:0];
            end
            if (v) sent++;
            if (f) begin
                exp_rreq = 1'b0; exp_wreq = 1'b0; fin = 1;
            end
        end
        rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        tick;
        exp_rv = '0; exp_gnt = '0;
        if (sent == int'(len)) exp_done = oh; else exp_err = oh;
        tick;
        exp_done = '0; exp_err = '0;
        ptr_m = (win + 1) % N;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int len, nb, sel;
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        tick;
        check("reset_rd_addr", rd_burst_addr, 0);
        check("reset_rdata", ch_rdata, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // round robin from reset with ch0 and ch2 both requesting
        check("pin_rr0", rr_pick(4'b0101), 0);
        txn(4'b0101, 1'b0, 28'h100, 2, 2, 0, 0, 0, 32'h1, 1);
        check("pin_rr1", rr_pick(4'b0101), 2);
        txn(4'b0101, 1'b0, 28'h200, 2, 2, 0, 0, 0, 32'h5, 1);
        check("pin_rr2", rr_pick(4'b0101), 0);
        txn(4'b0101, 1'b1, 28'h300, 2, 2, 0, 0, 0, 32'h7, 1);
        check("pin_rr3", rr_pick(4'b0101), 2);
        txn(4'b0101, 1'b0, 28'h400, 1, 1, 1, 0, 0, 32'h9, 1);

        // single read on ch1, beats 0xA..0xD
        check("pin_single_rd", rr_pick(4'b0010), 1);
        txn(4'b0010, 1'b0, 28'h0008000, 4, 4, 0, 0, 0, 32'hA, 1);
        // write on ch3, words 0x11/0x22/0x33
        check("pin_write", rr_pick(4'b1000), 3);
        txn(4'b1000, 1'b1, 28'h0000040, 3, 3, 0, 0, 0, 32'h11, 1);
        // length errors, boundary lengths 64 (legal) and 65 (illegal)
        txn(4'b0001, 1'b0, 28'h10, 0, 0, 0, 0, 0, 0, 0);
        txn(4'b0100, 1'b1, 28'h20, 65, 0, 0, 0, 0, 0, 0);
        txn(4'b0010, 1'b0, 28'h30, 64, 64, 0, 0, 0, 0, 0);
        // watchdog and beat mismatch
        txn(4'b0001, 1'b0, 28'h50, 8, 0, 0, 1, 0, 0, 0);
        txn(4'b0100, 1'b0, 28'h60, 8, 6, 0, 0, 0, 0, 0);
        txn(4'b0100, 1'b1, 28'h70, 5, 6, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(65, 1023);
            else if (sel == 2) len = 64;
            else               len = $urandom_range(1, 8);
            nb = len;
            if ($urandom_range(0, 4) == 0) nb = (len > 1) ? len - 1 : len + 1;
            txn(4'($urandom_range(1, 15)), 1'($urandom), AW'($urandom), LW'(len), nb,
                1'($urandom), 0, 0, 0, 0);
        end

        // reset in the middle of a write burst, then ch0 must win
        txn(4'b1000, 1'b1, 28'h80, 8, 8, 0, 0, 3, 32'h21, 1);
        check("pin_after_reset", rr_pick(4'b1111), 0);
        txn(4'b1111, 1'b0, 28'h90, 3, 3, 0, 0, 0, 32'h31, 1);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
